// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow signal in clock_in cycles.
// Latency: edge detection 1 cycle (3 with CLOCK_METER_SYNC_EN); results registered 1 cycle after the terminating rise or timeout.
// Backpressure: none; start is ignored while busy, results held until the next accepted start or reset.
module clock_period_meter #(
   parameter int unsigned             COUNT_WIDTH    = 28,
   parameter logic [COUNT_WIDTH-1:0]  TIMEOUT_CYCLES = 28'd100000000
) (
   input  logic                   clock_in,
   input  logic                   reset,
   input  logic                   signal_in,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   timeout,
   output logic [COUNT_WIDTH-1:0] period,
   output logic [COUNT_WIDTH-1:0] high_time
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_RISE = 3'd1,
      ST_MEAS_HIGH = 3'd2,
      ST_MEAS_LOW  = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [COUNT_WIDTH-1:0] period_q, period_d;
   logic [COUNT_WIDTH-1:0] high_q, high_d;
   logic                   timeout_q, timeout_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   s_q, s_dly_q;
   logic                   samp_src;
   logic                   rise, fall;
   logic                   at_limit;
   logic [COUNT_WIDTH-1:0] cnt_inc;

`ifdef CLOCK_METER_SYNC_EN
   logic sync1_q, sync2_q;

   // Two-flop synchronizer for inputs that are asynchronous to clock_in.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= signal_in;
         sync2_q <= sync1_q;
      end
   end

   assign samp_src = sync2_q;
`else
   assign samp_src = signal_in;
`endif

   // Sample the input and keep a one-cycle-delayed copy for edge detection.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         s_q     <= 1'b0;
         s_dly_q <= 1'b0;
      end else begin
         s_q     <= samp_src;
         s_dly_q <= s_q;
      end
   end

   assign rise    = s_q & ~s_dly_q;
   assign fall    = ~s_q & s_dly_q;
   assign cnt_inc = cnt_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
   // >= rather than == so a fall landing exactly on the limit cannot let cnt run past it and wrap.
   assign at_limit = (cnt_q >= TIMEOUT_CYCLES);

   // State and datapath register update.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         high_q    <= '0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state, counter and result logic; exit events take priority over the timeout.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      high_d    = high_q;
      timeout_d = timeout_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_WAIT_RISE;
               cnt_d     = '0;
               timeout_d = 1'b0;
            end
         end
         ST_WAIT_RISE: begin
            if (rise) begin
               state_d = ST_MEAS_HIGH;
               cnt_d   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end else if (at_limit) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
               period_d  = '0;
               high_d    = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_MEAS_HIGH: begin
            if (fall) begin
               state_d = ST_MEAS_LOW;
               high_d  = cnt_q;
               cnt_d   = cnt_inc;
            end else if (at_limit) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
               period_d  = '0;
               high_d    = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_MEAS_LOW: begin
            if (rise) begin
               state_d  = ST_DONE;
               period_d = cnt_q;
            end else if (at_limit) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
               period_d  = '0;
               high_d    = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_WAIT_RISE) || (state_d == ST_MEAS_HIGH) ||
               (state_d == ST_MEAS_LOW);
      done_d = (state_d == ST_DONE);
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign timeout   = timeout_q;
   assign period    = period_q;
   assign high_time = high_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter with hand-computed expectations.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled there too.
// Every comparison goes through check_eq; one summary line at the end.
module tb_clock_period_meter;

   localparam int CW = 28;
`ifdef CLOCK_METER_SYNC_EN
   localparam int LAT_EXTRA = 2;
`else
   localparam int LAT_EXTRA = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          signal_in;
   logic          start;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;

   int total = 0;
   int bad   = 0;

   // Pattern generator state: signal_in = (ph < gen_hi), ph cycles over gen_per.
   logic gen_en  = 1'b0;
   int   gen_hi  = 8;
   int   gen_per = 17;
   int   ph      = 0;

   clock_period_meter #(
      .COUNT_WIDTH    (CW),
      .TIMEOUT_CYCLES (28'd50)
   ) dut (
      .clock_in  (clk),
      .reset     (reset),
      .signal_in (signal_in),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .timeout   (timeout),
      .period    (period),
      .high_time (high_time)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (gen_en) begin
         signal_in = (ph < gen_hi);
         ph = (ph + 1) % gen_per;
      end
   endtask

   task automatic settle_low();
      gen_en    = 1'b0;
      signal_in = 1'b0;
      ph        = 0;
      repeat (5) step();
   endtask

   // Pulse start, then run until done (bounded). n counts edges from the start edge to the first done cycle.
   task automatic run_meas(input string tag, input int restart_at, output int n);
      start = 1'b1;
      step();
      start = 1'b0;
      n = 1;
      check_eq({tag, "_busy_after_start"}, 32'(busy), 32'd1);
      check_eq({tag, "_done_after_start"}, 32'(done), 32'd0);
      while (!done && n < 300) begin
         if (n == restart_at) start = 1'b1;
         step();
         start = 1'b0;
         n++;
         if (restart_at > 0 && n == restart_at + 1)
            check_eq({tag, "_restart_ignored_busy"}, 32'(busy), 32'd1);
      end
      check_eq({tag, "_done"}, 32'(done), 32'd1);
      check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      start     = 1'b0;
      signal_in = 1'b0;
      repeat (3) step();
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_timeout", 32'(timeout), 32'd0);
      check_eq("rst_period", 32'(period), 32'd0);
      check_eq("rst_high", 32'(high_time), 32'd0);
      reset = 1'b0;
      settle_low();

      // Period 17, high 8, with an ignored start mid-measurement.
      gen_hi = 8; gen_per = 17; ph = 0; gen_en = 1'b1;
      run_meas("p17", 6, n);
      check_eq("p17_latency", 32'(n), 32'(20 + LAT_EXTRA));
      check_eq("p17_timeout", 32'(timeout), 32'd0);
      check_eq("p17_period", 32'(period), 32'd17);
      check_eq("p17_high", 32'(high_time), 32'd8);

      // Constant low input from DONE: timeout after the counter reaches 50.
      settle_low();
      check_eq("hold_done", 32'(done), 32'd1);
      check_eq("hold_period", 32'(period), 32'd17);
      run_meas("tmo", 0, n);
      check_eq("tmo_latency", 32'(n), 32'd52);
      check_eq("tmo_timeout", 32'(timeout), 32'd1);
      check_eq("tmo_period", 32'(period), 32'd0);
      check_eq("tmo_high", 32'(high_time), 32'd0);

      // Period 4, high 1, input high on the start cycle.
      gen_hi = 1; gen_per = 4; ph = 0; gen_en = 1'b1;
      step();
      check_eq("p4_high_at_start", 32'(signal_in), 32'd1);
      run_meas("p4", 0, n);
      check_eq("p4_timeout", 32'(timeout), 32'd0);
      check_eq("p4_period", 32'(period), 32'd4);
      check_eq("p4_high", 32'(high_time), 32'd1);

      // Reset in the middle of the low phase.
      settle_low();
      gen_hi = 8; gen_per = 17; ph = 0; gen_en = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (13) step();
      check_eq("mid_busy", 32'(busy), 32'd1);
      check_eq("mid_high", 32'(high_time), 32'd8);
      check_eq("mid_period_held", 32'(period), 32'd4);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("mrst_busy", 32'(busy), 32'd0);
      check_eq("mrst_done", 32'(done), 32'd0);
      check_eq("mrst_timeout", 32'(timeout), 32'd0);
      check_eq("mrst_period", 32'(period), 32'd0);
      check_eq("mrst_high", 32'(high_time), 32'd0);

      // Fresh measurement after the reset.
      settle_low();
      gen_hi = 8; gen_per = 17; ph = 0; gen_en = 1'b1;
      run_meas("post", 0, n);
      check_eq("post_latency", 32'(n), 32'(20 + LAT_EXTRA));
      check_eq("post_timeout", 32'(timeout), 32'd0);
      check_eq("post_period", 32'(period), 32'd17);
      check_eq("post_high", 32'(high_time), 32'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
